// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters (video fetch, Z80) and the RAM macro.
interface vram_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic          vid_req;
  logic [AW-1:0] vid_ad;
  logic          vid_gnt;
  logic          vid_valid;
  logic [DW-1:0] vid_data;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_ad;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_wait;
  logic          cpu_valid;
  logic [DW-1:0] cpu_rdata;

  logic          ram_ce;
  logic          ram_oce;
  logic          ram_wre;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport master (
    output vid_req, vid_ad, cpu_req, cpu_we, cpu_ad, cpu_wdata, ram_dout,
    input  vid_gnt, vid_valid, vid_data, cpu_gnt, cpu_wait, cpu_valid, cpu_rdata,
    input  ram_ce, ram_oce, ram_wre, ram_ad, ram_din
  );

  modport slave (
    input  vid_req, vid_ad, cpu_req, cpu_we, cpu_ad, cpu_wdata, ram_dout,
    output vid_gnt, vid_valid, vid_data, cpu_gnt, cpu_wait, cpu_valid, cpu_rdata,
    output ram_ce, ram_oce, ram_wre, ram_ad, ram_din
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video has priority, CPU is guaranteed a slot after STREAK video wins.
module vram_arbiter #(
  parameter int AW     = 13,
  parameter int DW     = 8,
  parameter int RD_LAT = 1,
  parameter int STREAK = 4
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  localparam logic [3:0] STREAK_MAX = 4'(STREAK);

  logic [3:0]      streak;
  logic            vid_gnt;
  logic            cpu_gnt;
  logic            rd_issue;
  logic [RD_LAT:0] tag_v;
  logic [RD_LAT:0] tag_c;

  // No grants while reset is held, so nothing can be issued into a clearing pipeline.
  always_comb begin
    vid_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (reset) begin
      if (bus.vid_req && !(bus.cpu_req && streak == STREAK_MAX))
        vid_gnt = 1'b1;
      else if (bus.cpu_req)
        cpu_gnt = 1'b1;
    end
  end

  assign bus.vid_gnt  = vid_gnt;
  assign bus.cpu_gnt  = cpu_gnt;
  assign bus.cpu_wait = bus.cpu_req & ~cpu_gnt;
  assign rd_issue     = vid_gnt | (cpu_gnt & ~bus.cpu_we);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (!bus.cpu_req || cpu_gnt) begin
      streak <= '0;
    end else if (vid_gnt && streak != STREAK_MAX) begin
      streak <= streak + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ram_ce  <= 1'b0;
      bus.ram_oce <= 1'b0;
      bus.ram_wre <= 1'b0;
      bus.ram_ad  <= '0;
      bus.ram_din <= '0;
    end else begin
      bus.ram_ce  <= vid_gnt | cpu_gnt;
      bus.ram_wre <= cpu_gnt & bus.cpu_we;
      bus.ram_oce <= rd_issue;
      if (vid_gnt || cpu_gnt) begin
        bus.ram_ad  <= vid_gnt ? bus.vid_ad : bus.cpu_ad;
        bus.ram_din <= bus.cpu_wdata;
      end
    end
  end

  // Stage RD_LAT lines up with ram_dout; the return registers sample one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v         <= '0;
      tag_c         <= '0;
      bus.vid_valid <= 1'b0;
      bus.vid_data  <= '0;
      bus.cpu_valid <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      tag_v         <= {tag_v[RD_LAT-1:0], rd_issue};
      tag_c         <= {tag_c[RD_LAT-1:0], cpu_gnt};
      bus.vid_valid <= 1'b0;
      bus.cpu_valid <= 1'b0;
      if (tag_v[RD_LAT]) begin
        if (tag_c[RD_LAT]) begin
          bus.cpu_valid <= 1'b1;
          bus.cpu_rdata <= bus.ram_dout;
        end else begin
          bus.vid_valid <= 1'b1;
          bus.vid_data  <= bus.ram_dout;
        end
      end
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_vram_arbiter;
  localparam int AW     = 13;
  localparam int DW     = 8;
  localparam int STREAK = 4;
  localparam int LAT1   = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  vram_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
  vram_arbiter_if #(.AW(AW), .DW(DW)) b3 ();

  vram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT1), .STREAK(STREAK)) u_dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );
  vram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .STREAK(STREAK)) u_dut3 (
    .clk(clk), .reset(reset), .bus(b3)
  );

  // RAM models: 1-cycle and 3-cycle read latency from registered ram_ce.
  logic [7:0] mem1 [0:8191];
  logic [7:0] mem3 [0:8191];
  logic [7:0] p3a, p3b;

  always @(posedge clk) begin
    if (b1.ram_ce && b1.ram_wre) mem1[b1.ram_ad] <= b1.ram_din;
    if (b1.ram_ce && b1.ram_oce) b1.ram_dout <= mem1[b1.ram_ad];
  end

  always @(posedge clk) begin
    if (b3.ram_ce && b3.ram_wre) mem3[b3.ram_ad] <= b3.ram_din;
    if (b3.ram_ce && b3.ram_oce) p3a <= mem3[b3.ram_ad];
    p3b         <= p3a;
    b3.ram_dout <= p3b;
  end

  task automatic idle(input int n);
    b1.vid_req = 1'b0;
    b1.cpu_req = 1'b0;
    b3.vid_req = 1'b0;
    b3.cpu_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [42:0] obs;
    reset      = 1'b0;
    b1.vid_req = 1'b1;
    b1.vid_ad  = 13'h0123;
    repeat (3) @(negedge clk);
    obs = {b1.ram_ce, b1.ram_oce, b1.ram_wre, b1.ram_ad, b1.ram_din, b1.vid_valid,
           b1.cpu_valid, b1.vid_data, b1.cpu_rdata, b1.vid_gnt};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    reset = 1'b1;
    #1;
    total++;
    if (b1.vid_gnt !== 1'b1 || b1.cpu_gnt !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_gnt: got vid=%b cpu=%b expected vid=1 cpu=0", b1.vid_gnt, b1.cpu_gnt);
    end
    @(negedge clk);
    b1.vid_req = 1'b0;
    total++;
    if ({b1.ram_ce, b1.ram_oce, b1.ram_wre, b1.ram_ad} !== {3'b110, 13'h0123}) begin
      bad++;
      $display("FAIL reset_first_issue: got ce=%b oce=%b wre=%b ad=%h expected 1 1 0 0123",
               b1.ram_ce, b1.ram_oce, b1.ram_wre, b1.ram_ad);
    end
    idle(4);
  endtask

  task automatic test_write_read();
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_ad = 13'h1ABC; b1.cpu_wdata = 8'h5A;
    #1;
    total++;
    if (b1.cpu_gnt !== 1'b1 || b1.cpu_wait !== 1'b0) begin
      bad++;
      $display("FAIL wr_grant: got gnt=%b wait=%b expected 1 0", b1.cpu_gnt, b1.cpu_wait);
    end
    @(negedge clk);
    total++;
    if ({b1.ram_ce, b1.ram_oce, b1.ram_wre, b1.ram_ad, b1.ram_din} !== {3'b101, 13'h1ABC, 8'h5A}) begin
      bad++;
      $display("FAIL wr_issue: got ce=%b oce=%b wre=%b ad=%h din=%h expected 1 0 1 1abc 5a",
               b1.ram_ce, b1.ram_oce, b1.ram_wre, b1.ram_ad, b1.ram_din);
    end
    b1.cpu_we = 1'b0;
    #1;
    total++;
    if (b1.cpu_wait !== 1'b0 || b1.cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rd_grant: got gnt=%b wait=%b expected 1 0", b1.cpu_gnt, b1.cpu_wait);
    end
    @(negedge clk);
    b1.cpu_req = 1'b0;
    total++;
    if ({b1.ram_ce, b1.ram_oce, b1.ram_wre} !== 3'b110) begin
      bad++;
      $display("FAIL rd_issue: got ce/oce/wre=%b expected 110", {b1.ram_ce, b1.ram_oce, b1.ram_wre});
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if (b1.cpu_valid !== (k == 3) || b1.vid_valid !== 1'b0) begin
        bad++;
        $display("FAIL rd_valid_c%0d: got cpu_valid=%b vid_valid=%b expected %b 0",
                 k, b1.cpu_valid, b1.vid_valid, (k == 3));
      end
      if (k >= 3) begin
        total++;
        if (b1.cpu_rdata !== 8'h5A) begin
          bad++;
          $display("FAIL rd_data_c%0d: got %h expected 5a", k, b1.cpu_rdata);
        end
      end
    end
    idle(3);
  endtask

  task automatic test_contention();
    int waits = 0;
    b1.vid_req = 1'b1; b1.vid_ad = 13'h1F10;
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_ad = 13'h1F00; b1.cpu_wdata = 8'hEE;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (b1.cpu_wait === 1'b1) waits++;
      total++;
      if (b1.vid_gnt !== (i % 5 != 4) || b1.cpu_gnt !== (i % 5 == 4) || b1.cpu_wait !== (i % 5 != 4)) begin
        bad++;
        $display("FAIL contention_c%0d: got vid=%b cpu=%b wait=%b expected vid=%b cpu=%b",
                 i, b1.vid_gnt, b1.cpu_gnt, b1.cpu_wait, (i % 5 != 4), (i % 5 == 4));
      end
      @(negedge clk);
    end
    total++;
    if (waits != 16) begin
      bad++;
      $display("FAIL contention_wait_count: got %0d expected 16", waits);
    end
    idle(4);
  endtask

  task automatic test_pipelined_video();
    for (int i = 0; i < 8; i++) begin
      b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_ad = AW'(i); b1.cpu_wdata = 8'(8'h10 + i);
      @(negedge clk);
    end
    b1.cpu_req = 1'b0;
    for (int c = 0; c < 13; c++) begin
      total++;
      if (b1.vid_valid !== (c >= 3 && c <= 10) || b1.cpu_valid !== 1'b0) begin
        bad++;
        $display("FAIL pipe_valid_c%0d: got vid_valid=%b cpu_valid=%b expected %b 0",
                 c, b1.vid_valid, b1.cpu_valid, (c >= 3 && c <= 10));
      end
      if (c >= 3 && c <= 10) begin
        total++;
        if (b1.vid_data !== 8'(8'h10 + c - 3)) begin
          bad++;
          $display("FAIL pipe_data_c%0d: got %h expected %h", c, b1.vid_data, 8'(8'h10 + c - 3));
        end
      end
      b1.vid_req = (c < 8);
      b1.vid_ad  = AW'(c);
      @(negedge clk);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_read();
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_ad = 13'h0003;
    @(negedge clk);
    b1.cpu_req = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (b1.cpu_rdata !== 8'h00 || b1.ram_ce !== 1'b0) begin
      bad++;
      $display("FAIL midrd_clear: got rdata=%h ce=%b expected 00 0", b1.cpu_rdata, b1.ram_ce);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (b1.cpu_valid !== 1'b0 || b1.cpu_rdata !== 8'h00) begin
        bad++;
        $display("FAIL midrd_c%0d: got valid=%b rdata=%h expected 0 00", c, b1.cpu_valid, b1.cpu_rdata);
      end
    end
  endtask

  task automatic test_rdlat3();
    b3.cpu_req = 1'b1; b3.cpu_we = 1'b1; b3.cpu_ad = 13'h0042; b3.cpu_wdata = 8'hC3;
    @(negedge clk);
    b3.cpu_req = 1'b0;
    b3.vid_req = 1'b1; b3.vid_ad = 13'h0042;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      b3.vid_req = 1'b0;
      total++;
      if (b3.vid_valid !== (k == 5)) begin
        bad++;
        $display("FAIL lat3_valid_c%0d: got %b expected %b", k, b3.vid_valid, (k == 5));
      end
      if (k == 5) begin
        total++;
        if (b3.vid_data !== 8'hC3) begin
          bad++;
          $display("FAIL lat3_data: got %h expected c3", b3.vid_data);
        end
      end
    end
    idle(2);
  endtask

  typedef struct {
    int         due;
    bit         is_cpu;
    logic [7:0] d;
  } ret_t;

  task automatic test_random();
    logic [7:0]  mem [0:15];
    ret_t        q[$];
    ret_t        r;
    bit          vid_pend = 0, cpu_pend = 0, cpu_w = 0;
    logic [3:0]  vid_a = '0, cpu_a = '0;
    logic [7:0]  cpu_d = '0;
    int          waited = 0, k = 0;
    bit          vg, cg, ev_v, ev_c;
    logic [7:0]  e_vdat = '0, e_crd = '0, e_din = '0;
    logic [12:0] e_ad = '0;
    bit          e_ce = 0, e_oce = 0, e_wre = 0;
    logic [41:0] exp_v, obs_v;

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 320; i++) begin
      ev_v = 0; ev_c = 0;
      if (q.size() > 0 && q[0].due == k) begin
        r = q.pop_front();
        if (r.is_cpu) begin ev_c = 1; e_crd = r.d; end
        else begin ev_v = 1; e_vdat = r.d; end
      end
      exp_v = {e_ce, e_oce, e_wre, e_ad, e_din, ev_v, ev_c, e_vdat, e_crd};
      obs_v = {b1.ram_ce, b1.ram_oce, b1.ram_wre, b1.ram_ad, b1.ram_din, b1.vid_valid,
               b1.cpu_valid, b1.vid_data, b1.cpu_rdata};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL rand_regs_c%0d: got %h expected %h", i, obs_v, exp_v);
      end

      // Requests are held until granted; a new one may start only once the previous is done.
      if (i < 16) begin
        cpu_pend = 1; cpu_w = 1; cpu_a = 4'(i); cpu_d = 8'($urandom);
      end else if (i < 300) begin
        if (!vid_pend && ($urandom % 3 != 0)) begin vid_pend = 1; vid_a = 4'($urandom); end
        if (!cpu_pend && ($urandom % 2 != 0)) begin
          cpu_pend = 1; cpu_w = 1'($urandom); cpu_a = 4'($urandom); cpu_d = 8'($urandom);
        end
      end
      b1.vid_req   = vid_pend;
      b1.vid_ad    = vid_pend ? {9'h000, vid_a} : 13'($urandom);
      b1.cpu_req   = cpu_pend;
      b1.cpu_we    = cpu_w;
      b1.cpu_ad    = {9'h000, cpu_a};
      b1.cpu_wdata = cpu_d;
      #1;
      vg = vid_pend && !(cpu_pend && waited >= STREAK);
      cg = cpu_pend && !vg;
      total++;
      if ({b1.vid_gnt, b1.cpu_gnt, b1.cpu_wait} !== {vg, cg, cpu_pend && !cg}) begin
        bad++;
        $display("FAIL rand_gnt_c%0d: got vid/cpu/wait=%b%b%b expected %b%b%b", i,
                 b1.vid_gnt, b1.cpu_gnt, b1.cpu_wait, vg, cg, cpu_pend && !cg);
      end

      e_ce = vg || cg;
      e_wre = cg && cpu_w;
      e_oce = vg || (cg && !cpu_w);
      if (vg || cg) begin
        e_ad  = vg ? {9'h000, vid_a} : {9'h000, cpu_a};
        e_din = cpu_d;
      end
      if (vg) begin
        q.push_back('{due: k + 2 + LAT1, is_cpu: 0, d: mem[vid_a]});
        vid_pend = 0;
      end
      if (cg) begin
        if (cpu_w) mem[cpu_a] = cpu_d;
        else q.push_back('{due: k + 2 + LAT1, is_cpu: 1, d: mem[cpu_a]});
      end
      if (!cpu_pend || cg) waited = 0;
      else if (vg && waited < STREAK) waited++;
      if (cg) cpu_pend = 0;
      k++;
      @(negedge clk);
    end
    idle(2);
  endtask

  initial begin
    b1.vid_req = 1'b0; b1.vid_ad = '0; b1.cpu_req = 1'b0; b1.cpu_we = 1'b0;
    b1.cpu_ad = '0; b1.cpu_wdata = '0;
    b3.vid_req = 1'b0; b3.vid_ad = '0; b3.cpu_req = 1'b0; b3.cpu_we = 1'b0;
    b3.cpu_ad = '0; b3.cpu_wdata = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_contention();
    test_pipelined_video();
    test_reset_mid_read();
    test_rdlat3();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares a single-port 8 KB video RAM between two requesters: the video fetch engine (priority) and the Z80 CPU (contended).
- Issues at most one RAM access per clock, registers all RAM control/address/data lines, and returns read data tagged to the originating requester.
- Includes a starvation guard so the CPU is never locked out for more than STREAK consecutive video slots.
- Sits between the CPU bus decode, the video address generator and the RAM macro.

Parameters:
- AW, 13, RAM address width.
- DW, 8, data width.
- RD_LAT, 1, RAM read latency in cycles from registered ram_ce to ram_dout valid; legal 1..3.
- STREAK, 4, maximum consecutive video grants while CPU is waiting; legal 1..15.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- vid_req  in  1  video read request; held until granted.
- vid_ad  in  AW  video read address.
- vid_gnt  out  1  combinational grant; transfer occurs on an edge with vid_req&vid_gnt.
- vid_valid  out  1  one-cycle pulse: vid_data valid.
- vid_data  out  DW  video read data.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_ad  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  combinational grant.
- cpu_wait  out  1  cpu_req & ~cpu_gnt (drives Z80 WAIT).
- cpu_valid  out  1  one-cycle pulse: cpu_rdata valid (reads only).
- cpu_rdata  out  DW  CPU read data; held until next CPU read completes.
- ram_ce  out  1  registered RAM chip enable.
- ram_oce  out  1  registered RAM output enable (1 for reads).
- ram_wre  out  1  registered write enable.
- ram_ad  out  AW  registered address.
- ram_din  out  DW  registered write data.
- ram_dout  in  DW  RAM read data.

Behaviour:
- Reset (reset low, asynchronous): ram_ce/ram_oce/ram_wre=0, ram_ad=0, ram_din=0, vid_valid=cpu_valid=0, vid_data=cpu_rdata=0, streak counter=0, in-flight tag pipeline cleared. Reads in flight at reset never produce a valid pulse.
- Grant (combinational, each cycle):
  - Only vid_req: vid_gnt=1.
  - Only cpu_req: cpu_gnt=1.
  - Both: vid_gnt=1 unless streak==STREAK, then cpu_gnt=1.
  - Never both grants high.
- Streak counter:
  - +1 on each video transfer while cpu_req=1, saturating at STREAK.
  - Clears on a CPU transfer, or any cycle with cpu_req=0.
- Issue: on an edge with a transfer, ram_ce=1, ram_ad=granted address, ram_wre=cpu_we for CPU (0 for video), ram_oce=~ram_wre, ram_din=cpu_wdata. Without a transfer, ram_ce/ram_oce/ram_wre go 0 and ram_ad/ram_din hold.
- Tag pipeline: RD_LAT+1 stage shift register of {valid, is_cpu}, loaded at the transfer edge for reads only.
- Return: if a transfer occurs at edge E, the valid pulse is high during the cycle starting RD_LAT+1 edges after E, with data = ram_dout sampled at that edge. Back-to-back reads return back-to-back in issue order.
- Writes: no valid pulse; write is complete when ram_ce/ram_wre are registered.
- cpu_wait is high in every cycle cpu_req=1 without cpu_gnt, including cycles lost to streak-limited video priority.
- Requester changes address/req after its transfer edge; the arbiter latches nothing else.

Test Plan:
- Reset: hold reset low 3 cycles with vid_req=1 → all outputs 0. Release → vid_gnt=1 first cycle, ram_ce=1 next cycle.
- CPU write then read: write 0x1ABC←0x5A, then read 0x1ABC (RD_LAT=1) → cpu_wait=0 throughout, cpu_valid pulses 2 cycles after the read transfer edge, cpu_rdata=0x5A and holds.
- Contention: vid_req and cpu_req both held high → 4 video grants, then 1 CPU grant, repeating. cpu_wait is high exactly 4 of every 5 cycles; streak clears after the CPU grant.
- Pipelined video: 8 consecutive video reads of 0x0000..0x0007 preloaded with 0x10..0x17 → vid_valid high 8 consecutive cycles, data 0x10..0x17 in order; no cpu_valid.
- Reset mid-read: issue CPU read, assert reset the next cycle → no cpu_valid ever appears and cpu_rdata=0.
- RD_LAT=3: single video read → vid_valid exactly 4 cycles after the transfer edge, with correct data.
